// File: rtl/vga_pkg.sv
// Shared constants for the 80x30 text-mode pixel pipeline: geometry,
// CGA palette, character RAM field offsets and the cell address helper.
package vga_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int GLYPH_W  = 8;
   localparam int GLYPH_H  = 16;
   localparam int COLS     = 80;
   localparam int ROWS     = 30;

   localparam int CD_CODE_LSB = 0;
   localparam int CD_FG_LSB   = 8;
   localparam int CD_BG_LSB   = 12;

   // Entry 15 first: packed concatenation fills from the top index down.
   localparam logic [15:0][11:0] PALETTE = {
      12'hFFF, 12'hFF5, 12'hF5F, 12'hF55, 12'h5FF, 12'h5F5, 12'h55F, 12'h555,
      12'hAAA, 12'hA50, 12'hA0A, 12'hA00, 12'h0AA, 12'h0A0, 12'h00A, 12'h000
   };

   // row*80 + col built as (row<<6) + (row<<4) + col, avoiding a multiplier.
   function automatic logic [11:0] cell_addr(input logic [5:0] row, input logic [6:0] col);
      logic [11:0] r;
      r = {6'd0, row};
      return (r << 6) + (r << 4) + {5'd0, col};
   endfunction

endpackage

// File: rtl/vga_text_renderer_if.sv
// Character RAM / font ROM read port used by the text renderer.
interface vga_text_renderer_if;
   logic [11:0] char_addr;
   logic [15:0] char_data;
   logic [11:0] font_addr;
   logic [7:0]  font_data;

   modport master (output char_addr, output font_addr, input char_data, input font_data);
   modport slave  (input char_addr, input font_addr, output char_data, output font_data);
endinterface

// File: rtl/vga_cursor_blink.sv
// Counts vsync falling edges and toggles the cursor blink phase every
// BLINK_FRAMES frames.
module vga_cursor_blink #(
   parameter int BLINK_FRAMES = 30
) (
   input  logic clk,
   input  logic rst_n,
   input  logic vsync_in,
   output logic blink_on
);

   localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic          vsync_d_r;
   logic [CW-1:0] frame_cnt_r;
   logic          phase_r;
   logic          fall_s;
   logic          wrap_s;

   // Falling-edge detect and wrap condition.
   always_comb begin
      fall_s = vsync_d_r & ~vsync_in;
      wrap_s = (frame_cnt_r == CW'(BLINK_FRAMES - 1));
   end

   // Frame counter and blink phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_d_r   <= 1'b1;
         frame_cnt_r <= '0;
         phase_r     <= 1'b0;
      end else begin
         vsync_d_r <= vsync_in;
         if (fall_s) begin
            if (wrap_s) begin
               frame_cnt_r <= '0;
               phase_r     <= ~phase_r;
            end else begin
               frame_cnt_r <= frame_cnt_r + 1'b1;
            end
         end
      end
   end

   assign blink_on = phase_r;

endmodule

// File: rtl/vga_text_renderer.sv
// Three-cycle text-mode pixel pipeline: character fetch, glyph fetch,
// palette lookup, with syncs delayed to stay aligned with rgb.
module vga_text_renderer
   import vga_pkg::*;
#(
   parameter int BLINK_FRAMES = 30
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       hsync_in,
   input  logic                       vsync_in,
   input  logic [9:0]                 xpos,
   input  logic [9:0]                 ypos,
   vga_text_renderer_if.master        mem,
   input  logic [6:0]                 cursor_col,
   input  logic [4:0]                 cursor_row,
   input  logic                       cursor_en,
   output logic [11:0]                rgb,
   output logic                       hsync_out,
   output logic                       vsync_out
);

   logic        active0_s, hit0_s, blink_on_s, pix_s;
   logic [11:0] addr0_s;
   logic [3:0]  idx_s;

   logic [11:0] char_addr_r, font_addr_r, rgb_r;
   logic [2:0]  xcol0_r, xcol1_r;
   logic [3:0]  grow0_r, fg1_r, bg1_r;
   logic        act0_r, act1_r, hit0_r, hit1_r;
   logic        hs0_r, hs1_r, hs3_r, vs0_r, vs1_r, vs3_r;

   vga_cursor_blink #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
      .clk      (clk),
      .rst_n    (rst_n),
      .vsync_in (vsync_in),
      .blink_on (blink_on_s)
   );

   // S0 decode: visibility, cell address and cursor hit.
   always_comb begin
      active0_s = (xpos < 10'(H_ACTIVE)) && (ypos < 10'(V_ACTIVE));
      addr0_s   = cell_addr(ypos[9:4], xpos[9:3]);
      hit0_s    = cursor_en && (xpos[9:3] == cursor_col) &&
                  (ypos[9:4] == {1'b0, cursor_row}) && (ypos[3:0] >= 4'd14);
   end

   // S2: glyph bit select, cursor inversion and colour index.
   always_comb begin
      pix_s = font_data_bit(mem.font_data, xcol1_r) ^ (hit1_r & blink_on_s);
      idx_s = pix_s ? fg1_r : bg1_r;
   end

   function automatic logic font_data_bit(input logic [7:0] row_bits, input logic [2:0] xcol);
      return row_bits[3'd7 - xcol];
   endfunction

   // Pipeline registers S0, S1 and the S3 output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         char_addr_r <= 12'd0;
         xcol0_r     <= 3'd0;
         grow0_r     <= 4'd0;
         act0_r      <= 1'b0;
         hit0_r      <= 1'b0;
         hs0_r       <= 1'b1;
         vs0_r       <= 1'b1;
         font_addr_r <= 12'd0;
         fg1_r       <= 4'd0;
         bg1_r       <= 4'd0;
         xcol1_r     <= 3'd0;
         act1_r      <= 1'b0;
         hit1_r      <= 1'b0;
         hs1_r       <= 1'b1;
         vs1_r       <= 1'b1;
         rgb_r       <= 12'h000;
         hs3_r       <= 1'b1;
         vs3_r       <= 1'b1;
      end else begin
         char_addr_r <= addr0_s;
         xcol0_r     <= xpos[2:0];
         grow0_r     <= ypos[3:0];
         act0_r      <= active0_s;
         hit0_r      <= hit0_s;
         hs0_r       <= hsync_in;
         vs0_r       <= vsync_in;
         font_addr_r <= {mem.char_data[CD_CODE_LSB +: 8], grow0_r};
         fg1_r       <= mem.char_data[CD_FG_LSB +: 4];
         bg1_r       <= mem.char_data[CD_BG_LSB +: 4];
         xcol1_r     <= xcol0_r;
         act1_r      <= act0_r;
         hit1_r      <= hit0_r;
         hs1_r       <= hs0_r;
         vs1_r       <= vs0_r;
         rgb_r       <= act1_r ? PALETTE[idx_s] : 12'h000;
         hs3_r       <= hs1_r;
         vs3_r       <= vs1_r;
      end
   end

   assign mem.char_addr = char_addr_r;
   assign mem.font_addr = font_addr_r;
   assign rgb           = rgb_r;
   assign hsync_out     = hs3_r;
   assign vsync_out     = vs3_r;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Scoreboard bench for vga_text_renderer: a reference model predicts
// char_addr, font_addr and {rgb,syncs} for every driven pixel.
module tb_vga_text_renderer;

   localparam int BF = 2;

   typedef struct {
      int          due;
      logic [31:0] exp;
      string       tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hsync_in, vsync_in;
   logic [9:0]  xpos, ypos;
   logic [6:0]  cursor_col;
   logic [4:0]  cursor_row;
   logic        cursor_en;
   logic [11:0] rgb;
   logic        hsync_out, vsync_out;

   logic [15:0] ram  [4096];
   logic [7:0]  font [4096];
   logic [11:0] pal  [16];

   exp_t q_ca[$], q_fa[$], q_px[$];
   int   cyc = 0;
   int   n_err = 0, n_chk = 0;
   int   cnt_m = 0;
   logic phase_m = 1'b0;
   logic prev_vs = 1'b1;

   vga_text_renderer_if mem ();

   vga_text_renderer #(.BLINK_FRAMES(BF)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .hsync_in   (hsync_in),
      .vsync_in   (vsync_in),
      .xpos       (xpos),
      .ypos       (ypos),
      .mem        (mem),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .cursor_en  (cursor_en),
      .rgb        (rgb),
      .hsync_out  (hsync_out),
      .vsync_out  (vsync_out)
   );

   always #5 clk = ~clk;

   always_comb begin
      mem.char_data = ram[mem.char_addr];
      mem.font_data = font[mem.font_addr];
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [11:0] model_rgb(input int x, input int y);
      logic [15:0] d;
      logic [7:0]  f;
      logic        pix, hit;
      logic [3:0]  idx;
      if (x >= 640 || y >= 480) return 12'h000;
      d   = ram[12'((y / 16) * 80 + x / 8)];
      f   = font[{d[7:0], 4'(y % 16)}];
      pix = f[7 - (x % 8)];
      hit = cursor_en && (x / 8 == int'(cursor_col)) && (y / 16 == int'(cursor_row)) && (y % 16 >= 14);
      if (hit && phase_m) pix = ~pix;
      idx = pix ? d[11:8] : d[15:12];
      return pal[idx];
   endfunction

   task automatic drive(input int x, input int y, input logic hs, input logic vs);
      exp_t        e;
      logic [11:0] ca;
      logic [15:0] d;
      @(negedge clk);
      xpos = 10'(x); ypos = 10'(y); hsync_in = hs; vsync_in = vs;
      if (prev_vs && !vs) begin
         if (cnt_m == BF - 1) begin
            cnt_m   = 0;
            phase_m = ~phase_m;
         end else begin
            cnt_m++;
         end
      end
      prev_vs = vs;
      ca = 12'((y >> 4) * 80 + (x >> 3));
      d  = ram[ca];
      e.due = cyc + 1; e.exp = {20'd0, ca};                        e.tag = "char_addr"; q_ca.push_back(e);
      e.due = cyc + 2; e.exp = {20'd0, d[7:0], 4'(y % 16)};         e.tag = "font_addr"; q_fa.push_back(e);
      e.due = cyc + 3; e.exp = {18'd0, model_rgb(x, y), hs, vs};    e.tag = "pixel";     q_px.push_back(e);
   endtask

   task automatic pulse_vsync();
      drive(650, 481, 1'b1, 1'b1);
      drive(650, 481, 1'b1, 1'b1);
      drive(650, 490, 1'b1, 1'b0);
      drive(650, 490, 1'b1, 1'b0);
      drive(650, 491, 1'b1, 1'b1);
   endtask

   task automatic draw_cursor_cell();
      for (int y = 12; y < 16; y++)
         for (int x = 0; x < 8; x++)
            drive(x, y, 1'b1, 1'b1);
   endtask

   // Scoreboard: compare every queued expectation on its due cycle.
   always @(posedge clk) begin
      exp_t e;
      cyc++;
      #1;
      while (q_ca.size() > 0 && q_ca[0].due == cyc) begin
         e = q_ca.pop_front();
         check_eq(e.tag, {20'd0, mem.char_addr}, e.exp);
      end
      while (q_fa.size() > 0 && q_fa[0].due == cyc) begin
         e = q_fa.pop_front();
         check_eq(e.tag, {20'd0, mem.font_addr}, e.exp);
      end
      while (q_px.size() > 0 && q_px[0].due == cyc) begin
         e = q_px.pop_front();
         check_eq(e.tag, {18'd0, rgb, hsync_out, vsync_out}, e.exp);
      end
   end

   initial begin
      pal = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
              12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};
      for (int i = 0; i < 4096; i++) begin
         ram[i]  = 16'($urandom);
         font[i] = 8'($urandom);
      end
      ram[0]        = 16'h1F41;
      font[12'h410] = 8'h18;
      font[12'h41C] = 8'h3C;
      font[12'h41D] = 8'h3C;
      font[12'h41E] = 8'hF0;
      font[12'h41F] = 8'h0F;
      ram[80]       = 16'h0FFF;
      ram[2400]     = 16'h0FFF;
      font[12'hFF0] = 8'hFF;

      rst_n = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
      xpos = 10'd0; ypos = 10'd0;
      cursor_en = 1'b0; cursor_col = 7'd0; cursor_row = 5'd0;

      // Reset holds outputs even with live stimulus.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         xpos = 10'($urandom_range(0, 639));
         ypos = 10'($urandom_range(0, 479));
         #1;
         check_eq("reset_pix", {18'd0, rgb, hsync_out, vsync_out}, {18'd0, 12'h000, 1'b1, 1'b1});
         check_eq("reset_addr", {8'd0, mem.char_addr, mem.font_addr}, 32'd0);
      end
      @(negedge clk);
      hsync_in = 1'b1; vsync_in = 1'b1; rst_n = 1'b1;

      for (int x = 0; x < 8; x++) drive(x, 0, 1'b1, 1'b1);
      drive(639, 479, 1'b1, 1'b1);
      drive(8, 16, 1'b1, 1'b1);
      drive(640, 0, 1'b1, 1'b1);
      drive(0, 480, 1'b1, 1'b1);
      drive(700, 500, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) drive(640 + i, 10, (i == 2 || i == 3) ? 1'b0 : 1'b1, 1'b1);
      for (int i = 0; i < 150; i++)
         drive(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'b1, 1'b1);

      pulse_vsync();
      cursor_en = 1'b1; cursor_col = 7'd0; cursor_row = 5'd0;
      for (int f = 0; f < 6; f++) begin
         draw_cursor_cell();
         pulse_vsync();
      end
      cursor_en = 1'b0;
      for (int f = 0; f < 4; f++) begin
         draw_cursor_cell();
         pulse_vsync();
      end
      cursor_en = 1'b1; cursor_col = 7'd80;
      for (int f = 0; f < 4; f++) begin
         draw_cursor_cell();
         drive(639, 15, 1'b1, 1'b1);
         pulse_vsync();
      end

      // Mid-frame reset while a white pixel and low hsync sit in the pipe.
      cursor_en = 1'b0; cursor_col = 7'd0;
      drive(3, 0, 1'b0, 1'b1);
      drive(3, 0, 1'b0, 1'b1);
      drive(3, 0, 1'b0, 1'b1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("midreset_pix", {18'd0, rgb, hsync_out, vsync_out}, {18'd0, 12'h000, 1'b1, 1'b1});
      check_eq("midreset_addr", {8'd0, mem.char_addr, mem.font_addr}, 32'd0);
      q_ca.delete(); q_fa.delete(); q_px.delete();
      cnt_m = 0; phase_m = 1'b0; prev_vs = 1'b1;
      @(negedge clk);
      @(negedge clk);
      hsync_in = 1'b1; vsync_in = 1'b1; rst_n = 1'b1;
      for (int x = 0; x < 8; x++) drive(x, 0, 1'b1, 1'b1);

      repeat (6) @(posedge clk);
      #2;
      check_eq("drain", 32'(q_ca.size() + q_fa.size() + q_px.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
